// File: rtl/carry_seg.sv
// carry_seg: purely combinational ripple segment built from per-bit carry
// multiplexers. Each bit passes the incoming carry when its select is 1 and
// injects its data bit otherwise; the sum is select XOR incoming carry.
module carry_seg #(
  parameter int N = 8
) (
  input  logic [N-1:0] S,
  input  logic [N-1:0] DI,
  input  logic         CIN,
  output logic [N-1:0] SUM,
  output logic         COUT,
  output logic         CMSB
);

  // w_c[i] is the carry into bit i; w_c[N] leaves the segment.
  logic [N:0] w_c;

  assign w_c[0] = CIN;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign w_c[i+1] = S[i] ? w_c[i] : DI[i];
    assign SUM[i]   = S[i] ^ w_c[i];
  end

  assign COUT = w_c[N];
  // Carry into the top bit of the segment; used to form signed overflow.
  assign CMSB = w_c[N-1];

endmodule

// File: rtl/carry_pipe_add.sv
// carry_pipe_add: two-stage pipelined add/subtract unit. The carry chain is
// cut after LO_BITS bits; the low sum bits and the mid-chain carry of an
// operation are registered together, and the high segment completes in the
// second stage from registered high operands.
//
// Flow control: VI qualifies the operation entering stage 1 and VO qualifies
// O/CO/OVF. There is no ready/back-pressure; CE advances every pipeline
// register together, R clears them all and wins over CE.
module carry_pipe_add #(
  parameter int WIDTH   = 16,
  parameter int LO_BITS = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             VI,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic [WIDTH-1:0] O,
  output logic             CO,
  output logic             OVF,
  output logic             VO
);

  localparam int HI_BITS = WIDTH - LO_BITS;

  // Operand conditioning: subtraction is A + ~B + 1, so the carry-in is
  // inverted under SUB (CI=1 then yields A - B - 1).
  logic [WIDTH-1:0] w_be;
  logic             w_ce;
  logic [WIDTH-1:0] w_s;

  assign w_be = SUB ? ~B : B;
  assign w_ce = CI ^ SUB;
  assign w_s  = A ^ w_be;

  // Low segment (stage 1, combinational part).
  logic [LO_BITS-1:0] w_sum_lo;
  logic               w_cmid;
  logic               w_unused_cmsb_lo;

  carry_seg #(.N(LO_BITS)) u_seg_lo (
    .S    (w_s[LO_BITS-1:0]),
    .DI   (A[LO_BITS-1:0]),
    .CIN  (w_ce),
    .SUM  (w_sum_lo),
    .COUT (w_cmid),
    .CMSB (w_unused_cmsb_lo)
  );

  // Stage-1 registers.
  logic [LO_BITS-1:0] r_sum_lo;
  logic               r_cmid;
  logic [HI_BITS-1:0] r_a_hi;
  logic [HI_BITS-1:0] r_be_hi;
  logic               r_v1;

  // Stage 1: capture low sum, mid carry and high operands of the same op.
  always_ff @(posedge C) begin
    if (R) begin
      r_sum_lo <= '0;
      r_cmid   <= 1'b0;
      r_a_hi   <= '0;
      r_be_hi  <= '0;
      r_v1     <= 1'b0;
    end else if (CE) begin
      r_sum_lo <= w_sum_lo;
      r_cmid   <= w_cmid;
      r_a_hi   <= A[WIDTH-1:LO_BITS];
      r_be_hi  <= w_be[WIDTH-1:LO_BITS];
      r_v1     <= VI;
    end
  end

  // High segment (stage 2, combinational part) from registered operands.
  logic [HI_BITS-1:0] w_s_hi;
  logic [HI_BITS-1:0] w_sum_hi;
  logic               w_cout_hi;
  logic               w_cmsb_hi;

  assign w_s_hi = r_a_hi ^ r_be_hi;

  carry_seg #(.N(HI_BITS)) u_seg_hi (
    .S    (w_s_hi),
    .DI   (r_a_hi),
    .CIN  (r_cmid),
    .SUM  (w_sum_hi),
    .COUT (w_cout_hi),
    .CMSB (w_cmsb_hi)
  );

  // Stage-2 output registers.
  logic [WIDTH-1:0] r_o;
  logic             r_co;
  logic             r_ovf;
  logic             r_vo;

  // Stage 2: register full result, raw carry out, overflow and valid.
  always_ff @(posedge C) begin
    if (R) begin
      r_o   <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
      r_vo  <= 1'b0;
    end else if (CE) begin
      r_o   <= {w_sum_hi, r_sum_lo};
      r_co  <= w_cout_hi;
      r_ovf <= w_cout_hi ^ w_cmsb_hi;
      r_vo  <= r_v1;
    end
  end

  assign O   = r_o;
  assign CO  = r_co;
  assign OVF = r_ovf;
  assign VO  = r_vo;

endmodule
